// File: rtl/warp_dispatcher_pkg.sv
// Shared types for the warp dispatcher slice.
// Kernel descriptor layout and identifier widths.
package warp_dispatcher_pkg;

  localparam int WARP_ID_W     = 4;
  localparam int THREAD_COUNT  = 8;
  localparam int NUM_CORES_DEF = 4;

  localparam logic [WARP_ID_W-1:0] INVALID_WARP = 4'hF;

  typedef struct packed {
    logic [WARP_ID_W-1:0]    warp_id;
    logic [THREAD_COUNT-1:0] thread_count;
    logic [31:0]             start_pc;
  } kernel_t;

  localparam kernel_t IDLE_KERNEL = '{
    warp_id:      INVALID_WARP,
    thread_count: '0,
    start_pc:     '0
  };

endpackage

// File: rtl/warp_dispatcher_kernel_fifo.sv
// Synchronous kernel descriptor FIFO.
// Push is refused when full, regardless of a same-cycle pop.
module kernel_fifo
  import warp_dispatcher_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  kernel_t                wdata,
  output kernel_t                rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  kernel_t        mem_q [DEPTH];
  logic [AW-1:0]  wr_q, wr_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           do_push;
  logic           do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem_q[rd_q];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push)
                    - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/warp_dispatcher.sv
// Kernel front-end: queues descriptors, dispatches round-robin
// to idle SIMD cores and reports completions one per cycle.
module warp_dispatcher
  import warp_dispatcher_pkg::*;
#(
  parameter int NUM_CORES   = NUM_CORES_DEF,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                kernel_valid_in,
  input  kernel_t                             kernel_in,
  output logic                                kernel_ready_out,
  output logic                                drop_out,
  output kernel_t                             core_kernel_out,
  output logic [NUM_CORES-1:0]                core_start_out,
  input  logic [NUM_CORES-1:0]                core_finished_in,
  input  logic [NUM_CORES-1:0][WARP_ID_W-1:0] core_finished_warp_in,
  output logic                                done_valid_out,
  output logic [WARP_ID_W-1:0]                done_warp_id_out,
  output logic [$clog2(NUM_CORES)-1:0]        done_core_id_out,
  output logic                                mismatch_out,
  output logic                                all_idle_out
);

  localparam int CW = $clog2(NUM_CORES);

  typedef logic [NUM_CORES-1:0][WARP_ID_W-1:0] warp_arr_t;

  kernel_t                  head;
  logic                     full, empty;
  logic [$clog2(QUEUE_DEPTH):0] fifo_cnt;
  logic                     push_ok, enq;

  logic [NUM_CORES-1:0]     busy_q, busy_d;
  logic [NUM_CORES-1:0]     pend_q, pend_d;
  warp_arr_t                rec_q, rec_d;
  warp_arr_t                fin_q, fin_d;
  logic [CW-1:0]            rr_q, rr_d;

  logic [NUM_CORES-1:0]     elig;
  logic [CW-1:0]            sel, idx;
  logic                     found, disp;
  logic [CW-1:0]            rep_idx;
  logic                     rep_found;

  logic [NUM_CORES-1:0]     start_q, start_d;
  kernel_t                  kout_q, kout_d;
  logic                     drop_q, drop_d;
  logic                     dv_q, dv_d;
  logic [WARP_ID_W-1:0]     dw_q, dw_d;
  logic [CW-1:0]            dc_q, dc_d;
  logic                     mm_q, mm_d;
  logic                     idle_q, idle_d;

  assign push_ok = kernel_valid_in && !full;
  assign enq     = push_ok && (kernel_in.thread_count != '0);

  kernel_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (enq),
    .pop   (disp),
    .wdata (kernel_in),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  // Round-robin scan starting at rr_q, wrapping by width truncation.
  always_comb begin
    elig  = ~busy_q & ~pend_q;
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = rr_q + CW'(k);
      if (!found && elig[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    disp = found && !empty;
  end

  always_comb begin
    rep_idx   = '0;
    rep_found = 1'b0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        rep_idx   = CW'(k);
        rep_found = 1'b1;
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    pend_d = pend_q;
    rec_d  = rec_q;
    fin_d  = fin_q;
    rr_d   = rr_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_finished_in[i] && busy_q[i]) begin
        busy_d[i] = 1'b0;
        pend_d[i] = 1'b1;
        fin_d[i]  = core_finished_warp_in[i];
      end
    end
    // A pending core is never busy, so clearing here cannot collide
    if (rep_found) pend_d[rep_idx] = 1'b0;
    start_d = '0;
    kout_d  = kout_q;
    if (disp) begin
      busy_d[sel]  = 1'b1;
      rec_d[sel]   = head.warp_id;
      rr_d         = sel + CW'(1);
      start_d[sel] = 1'b1;
      kout_d       = head;
    end
  end

  always_comb begin
    drop_d = push_ok && (kernel_in.thread_count == '0);
    dv_d   = rep_found;
    dw_d   = rep_found ? fin_q[rep_idx] : '0;
    dc_d   = rep_found ? rep_idx : '0;
    mm_d   = rep_found && (fin_q[rep_idx] != rec_q[rep_idx]);
    idle_d = (fifo_cnt == '0) && (busy_q == '0)
          && (pend_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q  <= '0;
      pend_q  <= '0;
      rec_q   <= '0;
      fin_q   <= '0;
      rr_q    <= '0;
      start_q <= '0;
      kout_q  <= IDLE_KERNEL;
      drop_q  <= 1'b0;
      dv_q    <= 1'b0;
      dw_q    <= '0;
      dc_q    <= '0;
      mm_q    <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      rec_q   <= rec_d;
      fin_q   <= fin_d;
      rr_q    <= rr_d;
      start_q <= start_d;
      kout_q  <= kout_d;
      drop_q  <= drop_d;
      dv_q    <= dv_d;
      dw_q    <= dw_d;
      dc_q    <= dc_d;
      mm_q    <= mm_d;
      idle_q  <= idle_d;
    end
  end

  assign kernel_ready_out = !full;
  assign drop_out         = drop_q;
  assign core_kernel_out  = kout_q;
  assign core_start_out   = start_q;
  assign done_valid_out   = dv_q;
  assign done_warp_id_out = dw_q;
  assign done_core_id_out = dc_q;
  assign mismatch_out     = mm_q;
  assign all_idle_out     = idle_q;

endmodule
